// File: rtl/tri_dispatch_ctrl.sv
// Triangle dispatch front-end: buffers whole triangles in a FIFO and feeds them to the rasterizer one at a time.
// Optional TRI_STATS_EN adds completed-triangle and WAIT_HI-timeout counters.
module tri_dispatch_ctrl #(
    parameter int COORD_W    = 3,
    parameter int ADDR_W     = 2,
    parameter int HI_TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 push,
    input  logic [6*COORD_W-1:0] tri_in,
    output logic                 full,
    output logic [ADDR_W:0]      fifo_cnt,
    output logic                 ovf,
    input  logic                 busy,
    output logic                 nt,
    output logic [COORD_W-1:0]   xo,
    output logic [COORD_W-1:0]   yo,
    output logic                 idle,
    output logic                 done
`ifdef TRI_STATS_EN
    ,
    output logic [15:0]          tri_cnt,
    output logic [7:0]           tmo_cnt
`endif
);

    localparam int TRI_W = 6 * COORD_W;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int TMR_W = (HI_TIMEOUT > 1) ? $clog2(HI_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_V1,
        S_V2,
        S_V3,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [TRI_W-1:0]   r_mem [DEPTH];
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic [ADDR_W:0]    r_cnt;
    logic               r_ovf;
    logic [TRI_W-1:0]   r_tri;
    logic [TMR_W-1:0]   r_tmr;

    logic               r_nt;
    logic [COORD_W-1:0] r_xo;
    logic [COORD_W-1:0] r_yo;
    logic               r_done;

    logic               w_full;
    logic               w_pop;
    logic               w_push_ok;
    logic               w_timeout;
    logic               w_to_idle;
    logic               w_nt_nxt;
    logic [COORD_W-1:0] w_xo_nxt;
    logic [COORD_W-1:0] w_yo_nxt;

    logic [COORD_W-1:0] w_x1, w_y1, w_x2, w_y2, w_x3, w_y3;

    assign w_x1 = r_tri[6*COORD_W-1 -: COORD_W];
    assign w_y1 = r_tri[5*COORD_W-1 -: COORD_W];
    assign w_x2 = r_tri[4*COORD_W-1 -: COORD_W];
    assign w_y2 = r_tri[3*COORD_W-1 -: COORD_W];
    assign w_x3 = r_tri[2*COORD_W-1 -: COORD_W];
    assign w_y3 = r_tri[COORD_W-1 -: COORD_W];

    assign w_full    = (r_cnt == (ADDR_W+1)'(DEPTH));
    assign w_pop     = (r_state == S_IDLE) && en && (r_cnt != '0) && !busy;
    // A full FIFO still accepts a push when the same edge pops an entry
    assign w_push_ok = push && (!w_full || w_pop);
    assign w_timeout = (r_state == S_WAIT_HI) && !busy && (r_tmr == TMR_W'(HI_TIMEOUT - 1));
    assign w_to_idle = w_timeout || ((r_state == S_WAIT_LO) && !busy);

    // FIFO storage carries no reset; validity is tracked by r_cnt
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= tri_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_tri    <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
                r_tri    <= r_mem[r_rd_ptr];
            end
            if (w_push_ok && !w_pop) begin
                r_cnt <= r_cnt + (ADDR_W+1)'(1);
            end else if (w_pop && !w_push_ok) begin
                r_cnt <= r_cnt - (ADDR_W+1)'(1);
            end
            if (push && !w_push_ok) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_pop) w_state_nxt = S_V1;
            S_V1:      w_state_nxt = S_V2;
            S_V2:      w_state_nxt = S_V3;
            S_V3:      w_state_nxt = S_WAIT_HI;
            S_WAIT_HI: begin
                if (busy) begin
                    w_state_nxt = S_WAIT_LO;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_LO: if (!busy) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Timer reads zero on the first WAIT_HI cycle because it is held clear elsewhere
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmr <= '0;
        end else if (r_state == S_WAIT_HI) begin
            r_tmr <= r_tmr + TMR_W'(1);
        end else begin
            r_tmr <= '0;
        end
    end

    always_comb begin
        w_nt_nxt = 1'b0;
        w_xo_nxt = '0;
        w_yo_nxt = '0;
        case (r_state)
            S_V1: begin
                w_nt_nxt = 1'b1;
                w_xo_nxt = w_x1;
                w_yo_nxt = w_y1;
            end
            S_V2: begin
                w_xo_nxt = w_x2;
                w_yo_nxt = w_y2;
            end
            S_V3: begin
                w_xo_nxt = w_x3;
                w_yo_nxt = w_y3;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_nt   <= 1'b0;
            r_xo   <= '0;
            r_yo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_nt   <= w_nt_nxt;
            r_xo   <= w_xo_nxt;
            r_yo   <= w_yo_nxt;
            r_done <= w_to_idle;
        end
    end

`ifdef TRI_STATS_EN
    logic [15:0] r_tri_cnt;
    logic [7:0]  r_tmo_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tri_cnt <= '0;
            r_tmo_cnt <= '0;
        end else begin
            if (w_to_idle) begin
                r_tri_cnt <= r_tri_cnt + 16'd1;
            end
            if (w_timeout && (r_tmo_cnt != '1)) begin
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end
        end
    end

    assign tri_cnt = r_tri_cnt;
    assign tmo_cnt = r_tmo_cnt;
`endif

    assign full     = w_full;
    assign fifo_cnt = r_cnt;
    assign ovf      = r_ovf;
    assign nt       = r_nt;
    assign xo       = r_xo;
    assign yo       = r_yo;
    assign done     = r_done;
    assign idle     = (r_state == S_IDLE) && (r_cnt == '0);

endmodule

// File: tb/tb_tri_dispatch_ctrl.sv
// Bench for tri_dispatch_ctrl: directed scenarios plus random traffic against a queue-based reference model.
module tb_tri_dispatch_ctrl;

    localparam int CW    = 3;
    localparam int AW    = 2;
    localparam int HT    = 8;
    localparam int DEPTH = 4;
    localparam int TW    = 6 * CW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          en = 1'b0;
    logic          push = 1'b0;
    logic          busy = 1'b0;
    logic [TW-1:0] tri_in = '0;
    logic          full;
    logic [AW:0]   fifo_cnt;
    logic          ovf;
    logic          nt;
    logic [CW-1:0] xo;
    logic [CW-1:0] yo;
    logic          idle;
    logic          done;
`ifdef TRI_STATS_EN
    logic [15:0]   tri_cnt;
    logic [7:0]    tmo_cnt;
`endif

    tri_dispatch_ctrl #(
        .COORD_W   (CW),
        .ADDR_W    (AW),
        .HI_TIMEOUT(HT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .push    (push),
        .tri_in  (tri_in),
        .full    (full),
        .fifo_cnt(fifo_cnt),
        .ovf     (ovf),
        .busy    (busy),
        .nt      (nt),
        .xo      (xo),
        .yo      (yo),
        .idle    (idle),
        .done    (done)
`ifdef TRI_STATS_EN
        ,
        .tri_cnt (tri_cnt),
        .tmo_cnt (tmo_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a queue of pending triangles plus a count of edges since the active one was popped
    logic [TW-1:0] q[$];
    bit            m_act;
    bit            m_lo;
    bit            m_ovf;
    int            ph;
    logic [TW-1:0] cur;
    logic          e_nt;
    logic          e_done;
    logic [CW-1:0] e_xo;
    logic [CW-1:0] e_yo;
    int            tri_n;
    int            tmo_n;
    bit            resp;
    int            bh;

    function automatic logic [CW-1:0] fld(input logic [TW-1:0] t, input int i);
        return t[(5-i)*CW +: CW];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_act  = 0;
        m_lo   = 0;
        m_ovf  = 0;
        ph     = 0;
        cur    = '0;
        e_nt   = 0;
        e_done = 0;
        e_xo   = '0;
        e_yo   = '0;
        tri_n  = 0;
        tmo_n  = 0;
        bh     = 0;
    endtask

    task automatic complete();
        m_act  = 0;
        e_done = 1;
        tri_n  = (tri_n + 1) % 65536;
    endtask

    task automatic model_step();
        int  old_size;
        bit  old_act;
        bit  pop;
        if (reset) begin
            model_clear();
            return;
        end
        old_size = q.size();
        old_act  = m_act;
        e_done   = 0;
        e_nt     = 0;
        e_xo     = '0;
        e_yo     = '0;
        if (m_act) begin
            ph++;
            if (ph >= 1 && ph <= 3) begin
                e_nt = (ph == 1);
                e_xo = fld(cur, 2*(ph-1));
                e_yo = fld(cur, 2*(ph-1)+1);
            end else if (ph >= 4) begin
                if (m_lo) begin
                    if (!busy) complete();
                end else if (busy) begin
                    m_lo = 1;
                end else if (ph - 4 == HT - 1) begin
                    complete();
                    if (tmo_n < 255) tmo_n++;
                end
            end
        end
        pop = !old_act && en && (old_size != 0) && !busy;
        if (pop) begin
            cur   = q.pop_front();
            m_act = 1;
            m_lo  = 0;
            ph    = 0;
        end
        if (push) begin
            if (old_size < DEPTH || pop) q.push_back(tri_in);
            else m_ovf = 1;
        end
    endtask

    task automatic check_all();
        chk("nt", 32'(nt), 32'(e_nt));
        chk("xo", 32'(xo), 32'(e_xo));
        chk("yo", 32'(yo), 32'(e_yo));
        chk("done", 32'(done), 32'(e_done));
        chk("fifo_cnt", 32'(fifo_cnt), 32'(q.size()));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("idle", 32'(idle), 32'(!m_act && q.size() == 0));
`ifdef TRI_STATS_EN
        chk("tri_cnt", 32'(tri_cnt), 32'(tri_n));
        chk("tmo_cnt", 32'(tmo_cnt), 32'(tmo_n));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        if (resp) begin
            if (m_act && ph == 3 && !m_lo) bh = 5;
            busy = (bh > 0);
            if (bh > 0) bh--;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push_one(input logic [TW-1:0] t);
        push   = 1'b1;
        tri_in = t;
        step();
        push   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        push  = 1'b0;
        en    = 1'b0;
        busy  = 1'b0;
        resp  = 0;
        step();
        reset = 1'b0;
    endtask

    logic [TW-1:0] t0;

    initial begin
        model_clear();
        resp = 0;
        #2;
        do_reset();
        chk("rst_idle", 32'(idle), 32'd1);

        // Single triangle with a rasterizer that holds busy for 5 cycles
        en   = 1'b1;
        resp = 1;
        t0   = {3'd1, 3'd1, 3'd4, 3'd1, 3'd1, 3'd7};
        push_one(t0);
        run(16);
        chk("t1_idle", 32'(idle), 32'd1);

        // Overflow, then drain four in order
        do_reset();
        for (int i = 0; i < 5; i++) push_one(TW'(32'h1000 + i * 32'h0421));
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_cnt", 32'(fifo_cnt), 32'd4);
        chk("ovf_flag", 32'(ovf), 32'd1);
        en   = 1'b1;
        resp = 1;
        run(60);

        // Rasterizer never raises busy
        do_reset();
        en = 1'b1;
        push_one(TW'(32'h2A5B3));
        run(20);
`ifdef TRI_STATS_EN
        chk("tmo_cnt1", 32'(tmo_cnt), 32'd1);
        chk("tri_cnt1", 32'(tri_cnt), 32'd1);
`endif

        // busy held while a triangle waits in IDLE
        do_reset();
        en   = 1'b1;
        busy = 1'b1;
        push_one(TW'(32'h13579));
        run(5);
        chk("hold_nt", 32'(nt), 32'd0);
        busy = 1'b0;
        resp = 1;
        run(18);

        // Asynchronous reset while the DUT is in V2
        do_reset();
        for (int i = 0; i < 5; i++) push_one(TW'(32'h0F0F0 + i));
        en = 1'b1;
        for (int i = 0; i < 10 && nt !== 1'b1; i++) step();
        chk("reach_v2", 32'(nt), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        check_all();
        step();
        reset = 1'b0;
        en    = 1'b0;

        // Full FIFO: pop and push on the same edge
        for (int i = 0; i < 4; i++) push_one(TW'(32'h30000 + i * 32'h111));
        en = 1'b1;
        push_one(TW'(32'h3FEDC));
        chk("fp_cnt", 32'(fifo_cnt), 32'd4);
        chk("fp_ovf", 32'(ovf), 32'd0);
        resp = 1;
        run(70);

        // Random traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            push   = ($urandom_range(0, 2) == 0);
            tri_in = TW'($urandom);
            en     = ($urandom_range(0, 9) < 8);
            busy   = ($urandom_range(0, 9) < 3);
            step();
        end
        push = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
